load_store_unit: RTL

Sequencer between the pipeline MEM stage and the byte-addressed data memory. Accepts one byte/half/word load or store per handshake, drives the memory's 2-bit read/write strobes, and performs read-modify-write for sub-word stores because the memory writes only whole words. Returns loads as big-endian values with sign or zero extension, and flags misaligned accesses.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/lsu_byte_lane.sv | 45 ++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, memory strobe value.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] MEM_STROBE_ON = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

  // Size 11 has no legal encoding and is rejected like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
interface load_store_unit_if;

  // Request handshake: a request transfers on a rising edge where req_valid && req_ready.
  // The requester holds its fields stable while req_valid is high and req_ready low.
  // resp_valid is a one-cycle pulse with no back-pressure.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_write;
  logic [1:0]  mem_read;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: big-endian load extraction with extension, and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        zero_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  // rb[k] is the byte at aligned address + k as returned by the memory.
  logic [3:0][7:0] rb;
  logic [3:0][7:0] wb;
  logic [1:0]      off_next;

  assign rb       = rdata;
  assign off_next = offset + 2'd1;

  always_comb begin
    load_data = '0;
    case (size)
      SZ_BYTE: load_data = {{24{~zero_ext & rb[offset][7]}}, rb[offset]};
      SZ_HALF: load_data = {{16{~zero_ext & rb[offset][7]}}, rb[offset], rb[off_next]};
      default: load_data = {rb[0], rb[1], rb[2], rb[3]};
    endcase
  end

  // Write side places byte k at bits [31-8k -: 8], the reverse of the read side.
  always_comb begin
    wb = rb;
    case (size)
      SZ_BYTE: wb[offset] = wdata[7:0];
      SZ_HALF: begin
        wb[offset]   = wdata[15:8];
        wb[off_next] = wdata[7:0];
      end
      default: wb = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
    endcase
    merged = {wb[0], wb[1], wb[2], wb[3]};
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between MEM stage and a word-write data memory (read-modify-write for sub-word stores).
// Define LSU_ALIGN_CHECK_EN to enable misalignment detection; otherwise offsets are forced to natural alignment.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output lsu_state_e         dbg_state
);

  lsu_state_e  state;
  logic        we_q;
  logic        zext_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] base_q;
  logic [31:0] wdata_q;

  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_write_q;
  logic [1:0]  mem_read_q;

  logic [1:0]  size_n;
  logic [1:0]  off_n;
  logic        mis_n;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    size_n = bus.req_size;
    off_n  = bus.req_addr[1:0];
    mis_n  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis_n  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    if (bus.req_size == 2'b11) size_n = SZ_WORD;
    case (size_n)
      SZ_HALF: off_n = {bus.req_addr[1], 1'b0};
      SZ_WORD: off_n = 2'b00;
      default: ;
    endcase
`endif
  end

  lsu_byte_lane u_lane (
    .size      (size_q),
    .offset    (off_q),
    .zero_ext  (zext_q),
    .rdata     (bus.mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      zext_q       <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      base_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 2'b00;
      mem_read_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          zext_q  <= bus.req_unsigned;
          size_q  <= size_n;
          off_q   <= off_n;
          base_q  <= bus.req_addr[31:2];
          wdata_q <= bus.req_wdata;
          if (mis_n) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state        <= RESP;
          end else if (bus.req_we && size_n == SZ_WORD) begin
            mem_write_q <= MEM_STROBE_ON;
            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
            mem_wdata_q <= bus.req_wdata;
            state       <= WR;
          end else begin
            mem_read_q <= MEM_STROBE_ON;
            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
            state      <= RD;
          end
        end
        RD: begin
          mem_read_q <= 2'b00;
          mem_addr_q <= '0;
          state      <= CAP;
        end
        // Read data is valid for this whole cycle, so it feeds the lane logic directly.
        CAP: if (we_q) begin
          mem_write_q <= MEM_STROBE_ON;
          mem_addr_q  <= {base_q, 2'b00};
          mem_wdata_q <= merged;
          state       <= WR;
        end else begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
          state        <= RESP;
        end
        WR: begin
          mem_write_q  <= 2'b00;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_read   = mem_read_q;
  assign dbg_state      = state;

endmodule
